// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised sequence detector: length-width sizing,
// pattern-length mask generation and length clamping.
package seq_det_pkg;

   localparam int unsigned MASK_W = 64;

   function automatic int unsigned calc_len_w(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

   function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MASK_W; i++) begin
         m[i] = (i < len);
      end
      return m;
   endfunction

   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky saturation flag.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         sat
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         sat_q, sat_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
      // The count holds at all-ones, so the flag stays set until a clear.
      sat_d = &cnt_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   assign cnt = cnt_q;
   assign sat = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with selectable overlap,
// registered one-cycle detect pulse and saturating match counter.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int unsigned          MAX_LEN     = 8,
   parameter int unsigned          CNT_W       = 8,
   parameter logic [MAX_LEN-1:0]   DEF_PATTERN = 8'b1011,
   parameter int unsigned          DEF_LEN     = 4,
   parameter bit                   DEF_OVERLAP = 1'b1,
   localparam int unsigned         LEN_W       = calc_len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_bit,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count,
   output logic               count_sat
);

   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               det_q, det_d;

   logic [MAX_LEN-1:0] hist_sh;
   logic [LEN_W-1:0]   fill_inc;
   logic [MAX_LEN-1:0] mask;
   logic               match;

   always_comb begin
      hist_sh  = {hist_q[MAX_LEN-2:0], in_bit};
      fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
      mask     = MAX_LEN'(len_mask(32'(len_q)));
      match    = in_valid && !cfg_load && (len_q != '0) && (fill_inc >= len_q)
                 && (((hist_sh ^ pat_q) & mask) == '0);

      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      hist_d = hist_q;
      fill_d = fill_q;
      det_d  = 1'b0;

      if (cfg_load) begin
         pat_d  = cfg_pattern;
         len_d  = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
         ovl_d  = cfg_overlap;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d = hist_sh;
         // Without overlap a match consumes the history, forcing len fresh bits.
         fill_d = (match && !ovl_q) ? '0 : fill_inc;
         det_d  = match;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pat_q  <= DEF_PATTERN;
         len_q  <= LEN_W'(clamp_len(DEF_LEN, MAX_LEN));
         ovl_q  <= DEF_OVERLAP;
         hist_q <= '0;
         fill_q <= '0;
         det_q  <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         det_q  <= det_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (match),
      .cnt (match_count),
      .sat (count_sat)
   );

   assign detected = det_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default instance plus a 2-bit counter
// instance sharing the same stimulus for saturation checks.
module tb_seq_detector_param;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_bit;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       cnt_clr;

   logic       det;
   logic [7:0] cnt;
   logic       sat;
   logic       det2;
   logic [1:0] cnt2;
   logic       sat2;

   int unsigned n_chk;
   int unsigned n_bad;

   seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .detected(det), .match_count(cnt), .count_sat(sat)
   );

   seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .detected(det2), .match_count(cnt2), .count_sat(sat2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned got,
                           input int unsigned exp);
      n_chk++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic bit_in(input logic b);
      in_valid = 1'b1;
      in_bit   = b;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc();
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
      cfg_load    = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = o;
      cyc();
      cfg_load = 1'b0;
   endtask

   task automatic clear_cnt();
      cnt_clr = 1'b1;
      cyc();
      cnt_clr = 1'b0;
   endtask

   logic [14:0] stream;
   logic [14:0] exp_ovl;
   logic [14:0] exp_nov;
   logic [7:0]  pat_a5;
   logic [5:0]  exp_det5;
   logic [11:0] exp_cnt5;

   initial begin
      n_chk = 0;
      n_bad = 0;
      rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
      stream   = 15'b010110110010110;
      exp_ovl  = 15'h2090;
      exp_nov  = 15'h2010;
      pat_a5   = 8'hA5;
      exp_det5 = 6'b111110;
      exp_cnt5 = {2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};

      idle(2);
      check_eq("rst_det", det, 0);
      check_eq("rst_cnt", cnt, 0);
      check_eq("rst_sat", sat, 0);
      rst = 1'b1;
      idle(1);

      // Default 1011 with overlap
      for (int i = 0; i < 15; i++) begin
         bit_in(stream[14-i]);
         check_eq($sformatf("t1_det_b%0d", i + 1), det, exp_ovl[i]);
      end
      check_eq("t1_cnt", cnt, 3);

      clear_cnt();
      check_eq("t2_clr", cnt, 0);
      load(8'b1011, 4'd4, 1'b0);
      for (int i = 0; i < 15; i++) begin
         bit_in(stream[14-i]);
         check_eq($sformatf("t2_det_b%0d", i + 1), det, exp_nov[i]);
      end
      check_eq("t2_cnt", cnt, 2);

      // Gaps in in_valid, then reset mid-pattern
      load(8'b1011, 4'd4, 1'b1);
      clear_cnt();
      bit_in(1'b1);
      bit_in(1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check_eq("t3_gap_det", det, 0);
      end
      bit_in(1'b1);
      check_eq("t3_pre_det", det, 0);
      bit_in(1'b1);
      check_eq("t3_det", det, 1);
      cyc();
      check_eq("t3_det_single", det, 0);
      check_eq("t3_cnt", cnt, 1);
      bit_in(1'b1);
      bit_in(1'b0);
      bit_in(1'b1);
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      check_eq("t3_rst_cnt", cnt, 0);
      bit_in(1'b1);
      check_eq("t3_rst_det", det, 0);
      check_eq("t3_rst_cnt2", cnt, 0);

      // Full-length pattern A5
      load(8'hA5, 4'd8, 1'b1);
      for (int i = 0; i < 8; i++) begin
         bit_in(pat_a5[7-i]);
         check_eq($sformatf("t4_a5_b%0d", i + 1), det, (i == 7) ? 1 : 0);
      end
      load(8'h00, 4'd0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         bit_in(1'b0);
         check_eq("t4_len0_det", det, 0);
      end
      load(8'hA5, 4'd12, 1'b1);
      for (int i = 0; i < 8; i++) begin
         bit_in(pat_a5[7-i]);
      end
      check_eq("t4_clamp_det", det, 1);
      // Bit presented alongside cfg_load must be discarded
      in_valid = 1'b1;
      in_bit   = 1'b1;
      load(8'b1011, 4'd4, 1'b1);
      in_valid = 1'b0;
      bit_in(1'b0);
      bit_in(1'b1);
      bit_in(1'b1);
      check_eq("t4_drop_det", det, 0);
      bit_in(1'b0);
      bit_in(1'b1);
      bit_in(1'b1);
      check_eq("t4_after_drop_det", det, 1);

      // Saturation with 2-bit counter, pattern 11
      clear_cnt();
      load(8'b11, 4'd2, 1'b1);
      for (int i = 0; i < 6; i++) begin
         bit_in(1'b1);
         check_eq($sformatf("t5_det_b%0d", i + 1), det2, exp_det5[i]);
         check_eq($sformatf("t5_cnt_b%0d", i + 1), cnt2, exp_cnt5[2*i +: 2]);
      end
      check_eq("t5_sat", sat2, 1);
      check_eq("t5_cnt_wide", cnt, 5);
      check_eq("t5_sat_wide", sat, 0);
      cnt_clr = 1'b1;
      bit_in(1'b1);
      cnt_clr = 1'b0;
      check_eq("t5_clr_det", det2, 1);
      check_eq("t5_clr_cnt", cnt2, 0);
      check_eq("t5_clr_sat", sat2, 0);
      check_eq("t5_clr_cnt_wide", cnt, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
